sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//  Initiator side of the single-port SRAM bus: the CPU's memory access unit that drives sram's we_n/addr/data_in
//  and samples its registered data_out. Accepts one read or write per valid/ready handshake from the Mano CPU
//  datapath (AR/DR), sequences the SRAM's 1-cycle registered read, returns data/ack on a held response channel.
//  Sits between the CPU control unit and the 4096x16 main memory.
// PARAMETERS
//  ADDR_WIDTH  16    width of req_addr and mem_addr (matches sram ADDR_WIDTH)
//  DATA_WIDTH  16    word width of all data ports
//  DATA_DEPTH  4096  number of implemented SRAM words (2^12)
// PORTS
//  clk          in   1           system clock, all state on posedge
//  rst_n        in   1           asynchronous active-low reset
//  req_valid    in   1           CPU request present
//  req_ready    out  1           controller can accept; 1 only in IDLE
//  req_we       in   1           1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  word address
//  req_wdata    in   DATA_WIDTH  write data
//  rsp_valid    out  1           response held until rsp_ready
//  rsp_ready    in   1           CPU consumes response
//  rsp_rdata    out  DATA_WIDTH  read data (0 for writes)
//  rsp_err      out  1           out-of-range access (see CONFIGURATION)
//  mem_we_n     out  1           to sram we_n, active-low write enable
//  mem_addr     out  ADDR_WIDTH  to sram addr
//  mem_data_in  out  DATA_WIDTH  to sram data_in
//  mem_data_out in   DATA_WIDTH  from sram data_out (registered, 1 cycle)
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    mem_we_n=1, mem_addr=0, mem_data_in=0. Reset acts immediately (async), no SRAM access survives it.
//  - States: IDLE, WR, RD1, RD2, RESP. Accept = req_valid & req_ready at edge E0; captures addr/wdata/we.
//  - IDLE -(accept, we=1)-> WR: mem_addr=req_addr, mem_data_in=req_wdata, mem_we_n=0 after E0.
//  - WR -> RESP at E1: SRAM writes at E1; mem_we_n returns 1 after E1 (low exactly one cycle); rsp_valid=1,
//    rsp_rdata=0. Write ack latency: 1 cycle after accept.
//  - IDLE -(accept, we=0)-> RD1: mem_addr=req_addr, mem_we_n=1. RD1 -> RD2 at E1 (SRAM samples addr).
//  - RD2 -> RESP at E2: rsp_rdata<=mem_data_out, rsp_valid=1. Read latency: 2 cycles after accept.
//  - RESP: outputs held stable; -> IDLE at first edge with rsp_ready=1; rsp_valid drops, req_ready rises same edge.
//  - mem_addr/mem_data_in hold last value in IDLE/RESP; mem_we_n is low only in WR, never two consecutive cycles.
//  - req_valid while req_ready=0 is ignored (not queued); no back-to-back: min 3 cycles/write, 4 cycles/read
//    with rsp_ready tied 1. Address DATA_DEPTH-1 (0x0FFF) is a normal access, no wrap logic.
//  - Reset mid-op: asserted in WR before E1 -> write dropped (mem_we_n already 1), SRAM word unchanged;
//    in RD1/RD2/RESP -> response discarded, rsp_valid=0.
// CONFIGURATION
//  SRAM_CTRL_RANGE_CHECK_EN defined: accept with req_addr >= DATA_DEPTH -> no SRAM access (mem_we_n stays 1,
//    mem_addr unchanged), next state RESP after 1 cycle with rsp_err=1, rsp_rdata=0 (read or write).
//  Not defined: rsp_err tied 0; every address forwarded unchanged to mem_addr.
// TESTING
//  1. rst_n low 2 cycles then high -> req_ready=1, rsp_valid=0, mem_we_n=1, mem_addr=0.
//  2. Write 0x1234 @0x005 -> mem_we_n low exactly 1 cycle, rsp_valid 1 cycle after accept, rsp_rdata=0.
//  3. Read @0x005 after test 2 -> rsp_valid 2 cycles after accept, rsp_rdata=0x1234, rsp_err=0.
//  4. Read with rsp_ready low 3 cycles -> rsp_valid/rsp_rdata held, req_ready=0, extra req_valid ignored.
//  5. Write 0xBEEF @0x0FFF, pull rst_n low in WR before next edge -> read @0x0FFF returns prior value.
//  6. RANGE_CHECK_EN, DATA_DEPTH=2048, write @0x0800 -> mem_we_n never low, rsp_err=1; without macro rsp_err=0.

Source files
------------

// File: rtl/sram_ctrl.sv
// SRAM access controller: one read/write per handshake, held response channel.
// Optional address range check enabled by defining SRAM_CTRL_RANGE_CHECK_EN.
module sram_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_we_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    localparam logic LP_RANGE_EN = 1'b1;
`else
    localparam logic LP_RANGE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD1,
        S_RD2,
        S_RESP
    } state_t;

    state_t                r_state, w_state;
    logic                  r_req_ready, w_req_ready;
    logic                  r_rsp_valid, w_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
    logic                  r_rsp_err, w_rsp_err;
    logic                  r_err_pend, w_err_pend;
    logic                  r_mem_we_n, w_mem_we_n;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data_in, w_mem_data_in;
    logic                  w_accept;
    logic                  w_oor;

    assign w_accept = req_valid && r_req_ready;
    assign w_oor    = LP_RANGE_EN && (32'(req_addr) >= 32'(DATA_DEPTH));

    always_comb begin
        w_state       = r_state;
        w_req_ready   = r_req_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_err_pend    = r_err_pend;
        w_mem_we_n    = 1'b1;
        w_mem_addr    = r_mem_addr;
        w_mem_data_in = r_mem_data_in;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_req_ready = 1'b0;
                    w_err_pend  = w_oor;
                    // Out-of-range requests reuse the write slot with no strobe
                    if (w_oor) begin
                        w_state = S_WR;
                    end else if (req_we) begin
                        w_state       = S_WR;
                        w_mem_we_n    = 1'b0;
                        w_mem_addr    = req_addr;
                        w_mem_data_in = req_wdata;
                    end else begin
                        w_state    = S_RD1;
                        w_mem_addr = req_addr;
                    end
                end
            end
            S_WR: begin
                w_state     = S_RESP;
                w_rsp_valid = 1'b1;
                w_rsp_rdata = '0;
                w_rsp_err   = r_err_pend;
            end
            S_RD1: begin
                w_state = S_RD2;
            end
            S_RD2: begin
                w_state     = S_RESP;
                w_rsp_valid = 1'b1;
                w_rsp_rdata = mem_data_out;
                w_rsp_err   = 1'b0;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                end
            end
            default: begin
                w_state     = S_IDLE;
                w_rsp_valid = 1'b0;
                w_req_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_err_pend    <= 1'b0;
            r_mem_we_n    <= 1'b1;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_state       <= w_state;
            r_req_ready   <= w_req_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_err_pend    <= w_err_pend;
            r_mem_we_n    <= w_mem_we_n;
            r_mem_addr    <= w_mem_addr;
            r_mem_data_in <= w_mem_data_in;
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign mem_we_n    = r_mem_we_n;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed and random requests against a behavioural
// SRAM and a word-level reference memory.
module tb_sram_ctrl;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_we_n;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    int n_err = 0;
    int n_chk = 0;
    logic [AW-1:0] exp_maddr = '0;
    logic [DW-1:0] exp_mdin = '0;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] sram [0:65535];

    always #5 clk = ~clk;

    sram_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DATA_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_we_n    (mem_we_n),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = '0;
    end

    always @(posedge clk) begin
        if (!mem_we_n) sram[mem_addr] <= mem_data_in;
        mem_data_out <= sram[mem_addr];
    end

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int hold);
        bit oor;
        logic [DW-1:0] exp_rd;
        oor = RC && (int'(addr) >= DEPTH);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        chk("idle_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        if (!oor) begin
            exp_maddr = addr;
            if (we) exp_mdin = wd;
        end
        chk("acc_ready", 32'(req_ready), 0);
        chk("acc_rspv", 32'(rsp_valid), 0);
        chk("acc_we_n", 32'(mem_we_n), (we && !oor) ? 0 : 1);
        chk("acc_addr", 32'(mem_addr), 32'(exp_maddr));
        chk("acc_din", 32'(mem_data_in), 32'(exp_mdin));
        if (!we && !oor) begin
            tick();
            chk("rd1_rspv", 32'(rsp_valid), 0);
            chk("rd1_we_n", 32'(mem_we_n), 1);
        end
        exp_rd = (we || oor) ? '0 : ref_rd(int'(addr));
        if (we && !oor) ref_mem[int'(addr)] = wd;
        tick();
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(rsp_err), 32'(oor));
        chk("rsp_we_n", 32'(mem_we_n), 1);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
            tick();
            chk("hold_rspv", 32'(rsp_valid), 1);
            chk("hold_rdata", 32'(rsp_rdata), 32'(exp_rd));
            chk("hold_ready", 32'(req_ready), 0);
            chk("hold_we_n", 32'(mem_we_n), 1);
            chk("hold_addr", 32'(mem_addr), 32'(exp_maddr));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("done_rspv", 32'(rsp_valid), 0);
        chk("done_ready", 32'(req_ready), 1);
        chk("done_we_n", 32'(mem_we_n), 1);
        chk("done_addr", 32'(mem_addr), 32'(exp_maddr));
    endtask

    initial begin
        logic [AW-1:0] ra;
        repeat (2) @(posedge clk);
        #1;
        chk("inrst_ready", 32'(req_ready), 1);
        chk("inrst_we_n", 32'(mem_we_n), 1);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_rspv", 32'(rsp_valid), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_we_n", 32'(mem_we_n), 1);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_din", 32'(mem_data_in), 0);

        do_req(1'b1, 16'h0005, 16'h1234, 0);
        do_req(1'b0, 16'h0005, 16'h0000, 0);
        do_req(1'b0, 16'h0005, 16'h0000, 3);

        do_req(1'b1, 16'h0FFF, 16'h5A5A, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0FFF;
        req_wdata = 16'hBEEF;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("wrrst_pre_we_n", 32'(mem_we_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("wrrst_we_n", 32'(mem_we_n), 1);
        chk("wrrst_rspv", 32'(rsp_valid), 0);
        chk("wrrst_ready", 32'(req_ready), 1);
        chk("wrrst_addr", 32'(mem_addr), 0);
        exp_maddr = '0;
        exp_mdin  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_req(1'b0, 16'h0FFF, 16'h0000, 0);

        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0005;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rdrst_rspv", 32'(rsp_valid), 0);
        chk("rdrst_ready", 32'(req_ready), 1);
        tick();
        chk("rdrst_rspv2", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        exp_maddr = '0;
        exp_mdin  = '0;
        tick();

        do_req(1'b1, 16'h0800, 16'hCAFE, 0);
        do_req(1'b0, 16'h0800, 16'h0000, 0);
        do_req(1'b1, 16'h1000, 16'hD00D, 0);
        do_req(1'b0, 16'h1000, 16'h0000, 1);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                ra = AW'($urandom_range(0, 7));
            else
                ra = AW'(32'h0FF8 + $urandom_range(0, 7));
            do_req(1'($urandom_range(0, 1)), ra, DW'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
